// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: slot record, RGB triple,
// glyph geometry and pipeline depth.
package sprite_pkg;

    localparam int GLYPH_ROWS  = 16;
    localparam int PIPE_LAT    = 2;
    // Field widths of sprite_t; the compositor's COORD_W and ROM_AW-4 must match these.
    localparam int SPR_COORD_W = 10;
    localparam int SPR_GLYPH_W = 7;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef struct packed {
        logic [SPR_COORD_W-1:0] x;
        logic [SPR_COORD_W-1:0] y;
        logic [SPR_GLYPH_W-1:0] glyph;
        rgb24_t                 color;
        logic                   vis;
    } sprite_t;

endpackage

// File: rtl/sprite_hit.sv
// Per-slot rectangle test plus row/column offsets of the current pixel inside the sprite.
module sprite_hit #(
    parameter int COORD_W = 10,
    parameter int SPR_W   = 8,
    parameter int SPR_H   = 16,
    parameter int COL_W   = 3,
    parameter int ROW_W   = 4
) (
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic               vis,
    output logic               hit,
    output logic [ROW_W-1:0]   row,
    output logic [COL_W-1:0]   col
);

    // One extra bit so a sprite near the right/bottom edge never wraps to column 0.
    logic [COORD_W:0] dx, dy, sx, sy;

    assign dx = {1'b0, draw_x};
    assign dy = {1'b0, draw_y};
    assign sx = {1'b0, spr_x};
    assign sy = {1'b0, spr_y};

    assign hit = vis
              && (dx >= sx) && (dx < sx + (COORD_W+1)'(SPR_W))
              && (dy >= sy) && (dy < sy + (COORD_W+1)'(SPR_H));

    assign col = draw_x[COL_W-1:0] - spr_x[COL_W-1:0];
    assign row = draw_y[ROW_W-1:0] - spr_y[ROW_W-1:0];

endmodule

// File: rtl/sprite_compositor.sv
// Double-buffered sprite slots composited over a background colour through a
// two-stage pipeline with a synchronous glyph ROM; per-frame rectangle collision flags.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 10,
    parameter int SPR_W       = 8,
    parameter int SPR_H       = 16,
    parameter int ROM_AW      = 11,
    localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     DrawX,
    input  logic [COORD_W-1:0]     DrawY,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [COORD_W-1:0]     wr_x,
    input  logic [COORD_W-1:0]     wr_y,
    input  logic [ROM_AW-5:0]      wr_glyph,
    input  logic [23:0]            wr_color,
    input  logic                   wr_vis,
    input  logic [23:0]            bg_color,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [SPR_W-1:0]       rom_data,
    output logic [7:0]             Red,
    output logic [7:0]             Green,
    output logic [7:0]             Blue,
    output logic                   rgb_valid,
    output logic [NUM_SPRITES-1:0] collision
);

    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(GLYPH_ROWS);

    // Handshake: pix_valid qualifies DrawX/DrawY in the cycle it is high; rgb_valid
    // qualifies Red/Green/Blue exactly two cycles later. There is no backpressure.

    sprite_t                shadow [NUM_SPRITES];
    sprite_t                active [NUM_SPRITES];
    rgb24_t                 bg;
    logic [NUM_SPRITES-1:0] hits;
    logic [NUM_SPRITES-1:0] acc;
    logic [ROW_W-1:0]       row [NUM_SPRITES];
    logic [COL_W-1:0]       col [NUM_SPRITES];
    logic [IDX_W-1:0]       win_idx;
    logic                   any_hit;
    logic                   multi_hit;
    logic                   wr_ok;

    logic                   s0_valid;
    logic                   s0_hit;
    logic [IDX_W-1:0]       s0_idx;
    logic [COL_W-1:0]       s0_col;
    logic                   pix_bit;
    rgb24_t                 pix_color;

    genvar g;
    generate
        for (g = 0; g < NUM_SPRITES; g++) begin : g_hit
            sprite_hit #(
                .COORD_W(COORD_W), .SPR_W(SPR_W), .SPR_H(SPR_H),
                .COL_W(COL_W), .ROW_W(ROW_W)
            ) u_hit (
                .draw_x(DrawX),
                .draw_y(DrawY),
                .spr_x (active[g].x),
                .spr_y (active[g].y),
                .vis   (active[g].vis),
                .hit   (hits[g]),
                .row   (row[g]),
                .col   (col[g])
            );
        end
    endgenerate

    always_comb begin
        win_idx = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hits[i]) win_idx = IDX_W'(i);
        end
    end

    assign any_hit   = pix_valid && (|hits);
    assign multi_hit = (hits & (hits - NUM_SPRITES'(1))) != '0;
    assign wr_ok     = wr_en && (int'(wr_idx) < NUM_SPRITES);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            bg        <= '0;
            acc       <= '0;
            collision <= '0;
        end else begin
            // A write in the frame_start cycle lands in shadow only: active copies the old value.
            if (wr_ok) begin
                shadow[wr_idx] <= '{x: wr_x, y: wr_y, glyph: wr_glyph,
                                    color: wr_color, vis: wr_vis};
            end
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) active[i] <= shadow[i];
                bg        <= bg_color;
                collision <= acc;
                acc       <= '0;
            end else if (pix_valid && multi_hit) begin
                acc <= acc | hits;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr <= '0;
            s0_valid <= 1'b0;
            s0_hit   <= 1'b0;
            s0_idx   <= '0;
            s0_col   <= '0;
        end else begin
            s0_valid <= pix_valid;
            s0_hit   <= any_hit;
            if (any_hit) begin
                rom_addr <= ROM_AW'({active[win_idx].glyph, row[win_idx]});
                s0_idx   <= win_idx;
                s0_col   <= col[win_idx];
            end
        end
    end

    // ROM row arrives this cycle; MSB is the leftmost column. No fall-through on a clear bit.
    assign pix_bit   = s0_hit && rom_data[COL_W'(SPR_W - 1) - s0_col];
    assign pix_color = pix_bit ? active[s0_idx].color : bg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            {Red, Green, Blue} <= '0;
            rgb_valid          <= 1'b0;
        end else begin
            {Red, Green, Blue} <= s0_valid ? pix_color : '0;
            rgb_valid          <= s0_valid;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed scoreboard bench: drivers push expected RGB plus due cycle; a negedge
// monitor pops and checks whenever rgb_valid is high.
module tb_sprite_compositor;
    import sprite_pkg::*;

    logic       Clk, Reset, frame_start, pix_valid;
    logic [9:0] DrawX, DrawY;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [9:0] wr_x, wr_y;
    logic [6:0] wr_glyph;
    logic [23:0] wr_color;
    logic       wr_vis;
    logic [23:0] bg_color;
    logic [10:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] Red, Green, Blue;
    logic       rgb_valid;
    logic [3:0] collision;

    logic [7:0]  rom_mem [0:2047];
    logic [39:0] exp_q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    localparam logic [23:0] BG1   = 24'h102030;
    localparam logic [23:0] BG2   = 24'h405060;
    localparam logic [23:0] CYAN  = 24'h00FFFF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;

    sprite_compositor dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_glyph(wr_glyph), .wr_color(wr_color),
        .wr_vis(wr_vis), .bg_color(bg_color), .rom_addr(rom_addr), .rom_data(rom_data),
        .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid), .collision(collision)
    );

    // Address register lives in the DUT; the array read completes the synchronous ROM.
    assign rom_data = rom_mem[rom_addr];

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_slot(input int idx, input int x, input int y, input int glyph,
                            input logic [23:0] color, input logic vis);
        wr_idx   = 2'(idx);
        wr_x     = 10'(x);
        wr_y     = 10'(y);
        wr_glyph = 7'(glyph);
        wr_color = color;
        wr_vis   = vis;
    endtask

    task automatic write_slot(input int idx, input int x, input int y, input int glyph,
                              input logic [23:0] color, input logic vis);
        set_slot(idx, x, y, glyph, color, vis);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pixel(input int x, input int y, input logic [23:0] exp);
        pix_valid = 1'b1;
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        exp_q.push_back({16'(cyc + PIPE_LAT), exp});
        tick();
        pix_valid = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        if (!Reset) begin
            if (rgb_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rgb_valid", 32'(rgb_valid), 32'd0);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    check("pixel_rgb", 32'({Red, Green, Blue}), 32'(e[23:0]));
                    check("pixel_latency", 32'(cyc[15:0]), 32'(e[39:24]));
                end
            end else begin
                check("rgb_zero_when_invalid", 32'({Red, Green, Blue}), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
        wr_en = 1'b0; set_slot(0, 0, 0, 0, 24'h0, 1'b0); bg_color = BG1;
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'h00;
        rom_mem[32] = 8'h80;  // glyph 2 row 0
        rom_mem[33] = 8'h01;  // glyph 2 row 1
        rom_mem[47] = 8'hFF;  // glyph 2 row 15
        rom_mem[48] = 8'hFF;  // glyph 3 row 0

        idle(3);
        check("reset_rgb", 32'({Red, Green, Blue}), 32'd0);
        check("reset_rgb_valid", 32'(rgb_valid), 32'd0);
        check("reset_collision", 32'(collision), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        Reset = 1'b0;
        idle(2);

        // Single sprite, glyph 2 at (320,240)
        write_slot(0, 320, 240, 2, CYAN, 1'b1);
        frame();
        pixel(320, 240, CYAN);
        idle(1);
        pixel(327, 240, BG1);
        pixel(327, 241, CYAN);
        pixel(328, 240, BG1);
        check("rom_addr_hold_on_miss", 32'(rom_addr), 32'd33);
        pixel(319, 240, BG1);
        pixel(320, 255, CYAN);
        pixel(320, 256, BG1);
        idle(3);

        // Two overlapping slots: priority, no fall-through, collision
        write_slot(0, 100, 100, 2, CYAN, 1'b1);
        write_slot(1, 100, 100, 3, RED, 1'b1);
        frame();
        pixel(100, 100, CYAN);
        pixel(101, 100, BG1);
        pixel(107, 115, CYAN);
        pixel(108, 100, BG1);
        idle(3);
        write_slot(1, 200, 100, 3, RED, 1'b1);
        frame();
        check("collision_overlap", 32'(collision), 32'h3);
        pixel(100, 100, CYAN);
        pixel(200, 100, RED);
        idle(3);
        frame();
        check("collision_cleared", 32'(collision), 32'h0);

        // Write coincident with frame_start takes effect one frame later
        set_slot(0, 50, 100, 2, CYAN, 1'b1);
        wr_en = 1'b1; frame_start = 1'b1;
        tick();
        wr_en = 1'b0; frame_start = 1'b0;
        pixel(100, 100, CYAN);
        pixel(50, 100, BG1);
        idle(3);
        frame();
        pixel(50, 100, CYAN);
        pixel(100, 100, BG1);
        idle(3);

        // Right-edge sprite must not wrap; bg sampled only at frame_start
        write_slot(2, 1020, 0, 3, GREEN, 1'b1);
        bg_color = BG2;
        frame();
        bg_color = 24'hABCDEF;
        pixel(1020, 0, GREEN);
        pixel(1023, 0, GREEN);
        pixel(3, 0, BG2);
        idle(3);

        // Reset mid-line with outputs and collision active
        bg_color = BG2;
        write_slot(1, 100, 100, 3, RED, 1'b1);
        write_slot(0, 100, 100, 2, CYAN, 1'b1);
        frame();
        pixel(100, 100, CYAN);
        idle(3);
        frame();
        check("collision_before_reset", 32'(collision), 32'h3);
        pixel(100, 100, CYAN);
        pixel(100, 100, CYAN);
        pixel(100, 100, CYAN);
        pix_valid = 1'b1;
        #2;
        check("rgb_valid_before_reset", 32'(rgb_valid), 32'd1);
        Reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_rgb", 32'({Red, Green, Blue}), 32'd0);
        check("async_reset_rgb_valid", 32'(rgb_valid), 32'd0);
        check("async_reset_collision", 32'(collision), 32'd0);
        pix_valid = 1'b0;
        idle(2);
        Reset = 1'b0;
        idle(2);
        frame();
        pixel(100, 100, BG2);
        pixel(1020, 0, BG2);
        idle(4);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
